// File: rtl/pmem_line_adaptor.sv
// Bridges the cache's 256-bit pmem line port to a 64-bit burst memory bus:
// reads are gathered beat by beat into one line, writes are streamed out from a latched copy.
module pmem_line_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pmem_address,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic [31:0]            mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [BURST_WIDTH-1:0] mem_wdata,
  input  logic [BURST_WIDTH-1:0] mem_rdata,
  input  logic                   mem_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next_s;
  logic                  last_beat_s;
  logic [LINE_WIDTH-1:0] line_buf_r;
  logic [31:0]           aligned_addr_s;

  // Offset bits are masked off so every burst starts on a line boundary.
  assign aligned_addr_s = pmem_address & 32'hFFFF_FFE0;
  assign last_beat_s    = (cnt_r == CNT_W'(BEATS - 1));

  // Beat counter successor, wrapping explicitly so non-power-of-two BEATS also works.
  always_comb begin
    cnt_next_s = {CNT_W{1'b0}};
    if (last_beat_s) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Burst sequencer; every output is a register so memory sees glitch-free commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      line_buf_r  <= {LINE_WIDTH{1'b0}};
      pmem_rdata  <= {LINE_WIDTH{1'b0}};
      pmem_resp   <= 1'b0;
      mem_address <= 32'h0000_0000;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= {BURST_WIDTH{1'b0}};
    end else begin
      pmem_resp <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pmem_write) begin
            state_r     <= WR_BURST;
            mem_address <= aligned_addr_s;
            line_buf_r  <= pmem_wdata;
            mem_wdata   <= pmem_wdata[BURST_WIDTH-1:0];
            cnt_r       <= {CNT_W{1'b0}};
            mem_write   <= 1'b1;
          end else if (pmem_read) begin
            state_r     <= RD_BURST;
            mem_address <= aligned_addr_s;
            cnt_r       <= {CNT_W{1'b0}};
            mem_read    <= 1'b1;
          end
        end
        RD_BURST: begin
          if (mem_resp) begin
            pmem_rdata[int'(cnt_r) * BURST_WIDTH +: BURST_WIDTH] <= mem_rdata;
            cnt_r <= cnt_next_s;
            if (last_beat_s) begin
              state_r   <= DONE;
              mem_read  <= 1'b0;
              pmem_resp <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          // Preload the next beat so mem_wdata is already stable when the beat is offered.
          if (mem_resp) begin
            cnt_r     <= cnt_next_s;
            mem_wdata <= line_buf_r[int'(cnt_next_s) * BURST_WIDTH +: BURST_WIDTH];
            if (last_beat_s) begin
              state_r   <= DONE;
              mem_write <= 1'b0;
              pmem_resp <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Directed bench for pmem_line_adaptor: expected lines, write beats and response cycles
// are queued when a request is issued and compared when the adaptor produces them.
module tb_pmem_line_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  typedef struct {
    logic [255:0] line;
    int           cyc;
    bit           is_read;
  } resp_t;

  resp_t        rq[$];
  logic [63:0]  wq[$];
  int           checks;
  int           errors;
  int           cyc;
  logic [255:0] last_line;

  pmem_line_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock: check the write beat on offer, drive memory, clock, then score any response.
  task automatic step(input logic r, input logic [63:0] d);
    resp_t e;
    if (mem_write === 1'b1) begin
      chk("wbeat_pending", 256'(wq.size() != 0), 256'(1));
      if (wq.size() != 0) begin
        chk("mem_wdata", 256'(mem_wdata), 256'(wq[0]));
        if (r) void'(wq.pop_front());
      end
    end
    mem_resp  = r;
    mem_rdata = d;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pmem_resp === 1'b1) begin
      chk("resp_expected", 256'(rq.size() != 0), 256'(1));
      if (rq.size() != 0) begin
        e = rq.pop_front();
        chk("resp_cycle", 256'(cyc), 256'(e.cyc));
        if (e.is_read) chk("pmem_rdata", pmem_rdata, e.line);
      end
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step(i[0] ? 1'b0 : 1'b1, {$urandom, $urandom});
      chk("idle_resp", 256'(pmem_resp), 256'(0));
      chk("idle_mem_read", 256'(mem_read), 256'(0));
      chk("idle_mem_write", 256'(mem_write), 256'(0));
      chk("idle_rdata", pmem_rdata, last_line);
    end
  endtask

  // pat bit i gives mem_resp for the i-th memory cycle after the launch cycle.
  task automatic read_burst(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input int plen);
    resp_t e;
    int b;
    e.line = line; e.cyc = cyc + 2 + plen; e.is_read = 1'b1;
    rq.push_back(e);
    pmem_address = addr;
    pmem_read    = 1'b1;
    step(1'b0, 64'h0);
    chk("rd_cmd", 256'(mem_read), 256'(1));
    chk("rd_addr", 256'(mem_address), 256'(addr & 32'hFFFF_FFE0));
    step(1'b0, 64'h0);
    b = 0;
    for (int i = 0; i < plen; i++) begin
      if (pat[i]) begin
        step(1'b1, line[b*64 +: 64]);
        b++;
      end else begin
        step(1'b0, {$urandom, $urandom});
      end
      if (b < 4) chk("rd_cmd_held", 256'(mem_read), 256'(1));
      chk("rd_addr_held", 256'(mem_address), 256'(addr & 32'hFFFF_FFE0));
    end
    chk("rd_cmd_drop", 256'(mem_read), 256'(0));
    pmem_read = 1'b0;
    step(1'b0, 64'h0);
    chk("rd_resp_count", 256'(rq.size()), 256'(0));
    last_line = line;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [255:0] line,
                             input logic [15:0] pat, input int plen, input logic also_read);
    resp_t e;
    e.line = line; e.cyc = cyc + 2 + plen; e.is_read = 1'b0;
    rq.push_back(e);
    for (int k = 0; k < 4; k++) wq.push_back(line[k*64 +: 64]);
    pmem_address = addr;
    pmem_wdata   = line;
    pmem_write   = 1'b1;
    pmem_read    = also_read;
    step(1'b0, 64'h0);
    chk("wr_cmd", 256'(mem_write), 256'(1));
    chk("wr_no_read", 256'(mem_read), 256'(0));
    chk("wr_addr", 256'(mem_address), 256'(addr & 32'hFFFF_FFE0));
    step(1'b0, 64'h0);
    for (int i = 0; i < plen; i++) begin
      step(pat[i], {$urandom, $urandom});
      chk("wr_addr_held", 256'(mem_address), 256'(addr & 32'hFFFF_FFE0));
    end
    chk("wr_cmd_drop", 256'(mem_write), 256'(0));
    chk("wr_beats_left", 256'(wq.size()), 256'(0));
    pmem_write = 1'b0;
    pmem_read  = 1'b0;
    step(1'b0, 64'h0);
    chk("wr_resp_count", 256'(rq.size()), 256'(0));
    chk("wr_rdata_kept", pmem_rdata, last_line);
  endtask

  initial begin
    logic [255:0] rline;
    logic [255:0] wline;
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b0; pmem_address = 32'h0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = 256'h0; mem_rdata = 64'h0; mem_resp = 1'b0;
    last_line = 256'h0;
    rline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    // Reset asserted between clock edges must clear outputs on its own.
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_read", 256'(mem_read), 256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_pmem_resp", 256'(pmem_resp), 256'(0));
    chk("rst_pmem_rdata", pmem_rdata, 256'h0);
    chk("rst_mem_address", 256'(mem_address), 256'(0));
    chk("rst_mem_wdata", 256'(mem_wdata), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    quiet(5);

    read_burst(32'h0000_1234, rline, 16'b1111, 4);
    read_burst(32'h0000_1234, rline, 16'b1011001, 7);
    quiet(2);
    write_burst(32'h8000_00E0, wline, 16'b1011010, 7, 1'b0);
    write_burst(32'h0000_2040, ~wline, 16'b1111, 4, 1'b1);
    quiet(3);

    // Abort a read after two beats.
    pmem_address = 32'h0000_4444;
    pmem_read    = 1'b1;
    step(1'b0, 64'h0);
    step(1'b0, 64'h0);
    step(1'b1, 64'h1234_5678_9ABC_DEF0);
    step(1'b1, 64'h0FED_CBA9_8765_4321);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_read", 256'(mem_read), 256'(0));
    chk("abort_pmem_resp", 256'(pmem_resp), 256'(0));
    chk("abort_rdata", pmem_rdata, 256'h0);
    chk("abort_mem_address", 256'(mem_address), 256'(0));
    @(negedge clk);
    rst       = 1'b0;
    pmem_read = 1'b0;
    mem_resp  = 1'b0;
    last_line = 256'h0;
    step(1'b0, 64'h0);
    chk("abort_idle", 256'(mem_read), 256'(0));
    read_burst(32'h0000_5678, {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                               64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000}, 16'b1111, 4);
    quiet(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
